// File: rtl/tsqr_pkg.sv
// Shared types and constants for the TSQR R-result sink.
package tsqr_pkg;

  localparam int BW_DEF = 64;

  // Number of stored elements in a COLS x COLS upper-triangular matrix
  function automatic int r_elems(input int cols);
    return cols * (cols + 1) / 2;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } tsqr_st_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_ZERO  = 2'd3;

endpackage

// File: rtl/tsqr_r_tri_buf.sv
// Upper-triangle R storage: packed slot register file with a registered
// full-matrix read port (lower triangle and out-of-range reads return 0).
module tsqr_r_tri_buf
  import tsqr_pkg::*;
#(
  parameter int BW   = BW_DEF,
  parameter int COLS = 2,
  parameter int IDXW = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int CW   = $clog2(r_elems(COLS) + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  input  logic            we,
  input  logic [CW-1:0]   wslot,
  input  logic [BW-1:0]   wdata,
  input  logic            rd_en,
  input  logic [IDXW-1:0] rd_row,
  input  logic [IDXW-1:0] rd_col,
  output logic [BW-1:0]   rd_data,
  output logic            rd_vld
);

  localparam int R_ELEMS = r_elems(COLS);
  localparam int SW      = (R_ELEMS > 1) ? $clog2(R_ELEMS) : 1;

  logic [BW-1:0] mem [R_ELEMS];
  int            r, c, slot;
  logic          in_tri;
  logic [SW-1:0] rs;

  // Row-major triangle slot: row*COLS - row*(row-1)/2 + (col-row); the
  // product row*(row-1) is always even so the halving is an exact shift.
  always_comb begin
    r      = int'(rd_row);
    c      = int'(rd_col);
    in_tri = (r < COLS) && (c < COLS) && (r <= c);
    slot   = r * COLS - ((r * (r - 1)) >>> 1) + (c - r);
    rs     = SW'(slot);
  end

  // Storage writes and registered read; a same-cycle read sees the old value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < R_ELEMS; i++) mem[i] <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      if (clr) begin
        for (int i = 0; i < R_ELEMS; i++) mem[i] <= '0;
      end else if (we) begin
        mem[SW'(wslot)] <= wdata;
      end
      rd_vld <= rd_en;
      if (rd_en) rd_data <= in_tri ? mem[rs] : '0;
    end
  end

endmodule

// File: rtl/tsqr_r_sink.sv
// TSQR R-result sink: arms on the enable rising edge, captures the
// upper-triangular R stream, checks beat count and exposes a read port.
module tsqr_r_sink
  import tsqr_pkg::*;
#(
  parameter int BW   = BW_DEF,
  parameter int COLS = 2,
  parameter int MXW  = 32,
  parameter int IDXW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int R_ELEMS = r_elems(COLS),
  localparam int CW      = $clog2(R_ELEMS + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_tsqr_en,
  input  logic [MXW-1:0]  io_mx_no,
  input  logic            io_r_vld,
  input  logic [BW-1:0]   io_r_0,
  input  logic            io_tsqr_fi,
  input  logic            io_rd_en,
  input  logic [IDXW-1:0] io_rd_row,
  input  logic [IDXW-1:0] io_rd_col,
  output logic [BW-1:0]   io_rd_data,
  output logic            io_rd_vld,
  output logic            io_done,
  output logic            io_err,
  output logic [1:0]      io_err_code,
  output logic [CW-1:0]   io_beat_cnt,
  output logic [MXW-1:0]  io_mx_lat
);

  tsqr_st_e      st;
  logic          en_q;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rise, fall, full, acc, clr;

  // en_q resets high so an enable already high at reset release is not
  // mistaken for an arming edge; a low period is always required.
  assign rise    = io_tsqr_en & ~en_q;
  assign fall    = ~io_tsqr_en & en_q;
  assign full    = (cnt == CW'(R_ELEMS));
  assign acc     = (st == ST_CAPTURE) && io_r_vld && !full && !fall;
  assign clr     = (st == ST_IDLE) && rise;
  assign cnt_nxt = cnt + CW'(acc);
  assign io_beat_cnt = cnt;

  // Run-control FSM, edge detect and beat counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st          <= ST_IDLE;
      en_q        <= 1'b1;
      cnt         <= '0;
      io_mx_lat   <= '0;
      io_done     <= 1'b0;
      io_err      <= 1'b0;
      io_err_code <= ERR_NONE;
    end else begin
      en_q <= io_tsqr_en;
      if (fall) begin
        st          <= ST_IDLE;
        io_done     <= 1'b0;
        io_err      <= 1'b0;
        io_err_code <= ERR_NONE;
      end else begin
        case (st)
          ST_IDLE: if (rise) begin
            io_mx_lat <= io_mx_no;
            cnt       <= '0;
            if (io_mx_no == '0) begin
              st          <= ST_ERROR;
              io_err      <= 1'b1;
              io_err_code <= ERR_ZERO;
            end else begin
              st          <= ST_CAPTURE;
              io_err_code <= ERR_NONE;
            end
          end
          ST_CAPTURE: begin
            // An overflowing beat wins over a same-cycle finish
            if (io_r_vld && full) begin
              st          <= ST_ERROR;
              io_err      <= 1'b1;
              io_err_code <= ERR_OVER;
            end else begin
              cnt <= cnt_nxt;
              if (io_tsqr_fi) begin
                if (cnt_nxt == CW'(R_ELEMS)) begin
                  st      <= ST_DONE;
                  io_done <= 1'b1;
                end else begin
                  st          <= ST_ERROR;
                  io_err      <= 1'b1;
                  io_err_code <= ERR_UNDER;
                end
              end
            end
          end
          ST_DONE: if (io_r_vld) begin
            st          <= ST_ERROR;
            io_done     <= 1'b0;
            io_err      <= 1'b1;
            io_err_code <= ERR_OVER;
          end
          default: ;
        endcase
      end
    end
  end

  tsqr_r_tri_buf #(.BW(BW), .COLS(COLS), .IDXW(IDXW), .CW(CW)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .we      (acc),
    .wslot   (cnt),
    .wdata   (io_r_0),
    .rd_en   (io_rd_en),
    .rd_row  (io_rd_row),
    .rd_col  (io_rd_col),
    .rd_data (io_rd_data),
    .rd_vld  (io_rd_vld)
  );

endmodule

// File: tb/tb_tsqr_r_sink.sv
// Bench for tsqr_r_sink: directed scenarios plus randomized runs, checked
// every cycle against a transaction-level model of the R capture.
module tb_tsqr_r_sink;
  import tsqr_pkg::*;

  localparam int BW = 64, COLS = 2, MXW = 32, IDXW = 1;
  localparam int R = 3, CW = 2;

  logic            clock = 1'b0, reset = 1'b0;
  logic            io_tsqr_en = 1'b0, io_r_vld = 1'b0, io_tsqr_fi = 1'b0, io_rd_en = 1'b0;
  logic [MXW-1:0]  io_mx_no = '0;
  logic [BW-1:0]   io_r_0 = '0;
  logic [IDXW-1:0] io_rd_row = '0, io_rd_col = '0;
  logic [BW-1:0]   io_rd_data;
  logic            io_rd_vld, io_done, io_err;
  logic [1:0]      io_err_code;
  logic [CW-1:0]   io_beat_cnt;
  logic [MXW-1:0]  io_mx_lat;

  tsqr_r_sink #(.BW(BW), .COLS(COLS), .MXW(MXW), .IDXW(IDXW)) dut (
    .clock(clock), .reset(reset), .io_tsqr_en(io_tsqr_en), .io_mx_no(io_mx_no),
    .io_r_vld(io_r_vld), .io_r_0(io_r_0), .io_tsqr_fi(io_tsqr_fi),
    .io_rd_en(io_rd_en), .io_rd_row(io_rd_row), .io_rd_col(io_rd_col),
    .io_rd_data(io_rd_data), .io_rd_vld(io_rd_vld), .io_done(io_done),
    .io_err(io_err), .io_err_code(io_err_code), .io_beat_cnt(io_beat_cnt),
    .io_mx_lat(io_mx_lat)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_mis = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Beat k lands at matrix position (br[k], bc[k]) of a plain 2D R matrix.
  int          br [R], bc [R];
  logic [63:0] m_r [COLS][COLS];
  int          m_cnt, m_code;
  bit          m_active, m_done, m_err, m_prev_en, m_rise, m_fall, m_rd_vld;
  logic [31:0] m_mx;
  logic [63:0] m_rd;

  initial begin
    int k = 0;
    for (int rr = 0; rr < COLS; rr++)
      for (int cc = rr; cc < COLS; cc++) begin br[k] = rr; bc[k] = cc; k++; end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < COLS; i++) for (int j = 0; j < COLS; j++) m_r[i][j] = '0;
      m_cnt = 0; m_code = 0; m_active = 0; m_done = 0; m_err = 0;
      m_prev_en = 1; m_mx = '0; m_rd = '0; m_rd_vld = 0;
    end else begin
      m_rise = io_tsqr_en && !m_prev_en;
      m_fall = !io_tsqr_en && m_prev_en;
      m_prev_en = io_tsqr_en;
      m_rd_vld = io_rd_en;
      if (io_rd_en)
        m_rd = (int'(io_rd_row) < COLS && int'(io_rd_col) < COLS) ? m_r[io_rd_row][io_rd_col] : '0;
      if (m_fall) begin
        m_active = 0; m_done = 0; m_err = 0; m_code = 0;
      end else if (!m_active && !m_done && !m_err && m_rise) begin
        m_mx = io_mx_no; m_cnt = 0; m_code = 0;
        for (int i = 0; i < COLS; i++) for (int j = 0; j < COLS; j++) m_r[i][j] = '0;
        if (io_mx_no == 0) begin m_err = 1; m_code = 3; end
        else m_active = 1;
      end else if (m_active) begin
        if (io_r_vld) begin
          if (m_cnt == R) begin m_err = 1; m_code = 2; m_active = 0; end
          else begin m_r[br[m_cnt]][bc[m_cnt]] = io_r_0; m_cnt++; end
        end
        if (m_active && io_tsqr_fi) begin
          m_active = 0;
          if (m_cnt == R) m_done = 1;
          else begin m_err = 1; m_code = 1; end
        end
      end else if (m_done && io_r_vld) begin
        m_done = 0; m_err = 1; m_code = 2;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("done", 64'(io_done), 64'(m_done));
      chk("err", 64'(io_err), 64'(m_err));
      chk("err_code", 64'(io_err_code), 64'(m_code));
      chk("beat_cnt", 64'(io_beat_cnt), 64'(m_cnt));
      chk("mx_lat", 64'(io_mx_lat), 64'(m_mx));
      chk("rd_vld", 64'(io_rd_vld), 64'(m_rd_vld));
      chk("rd_data", io_rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(negedge clock); #1; endtask

  task automatic arm(input logic [31:0] mx);
    io_tsqr_en = 0; tick(); tick();
    io_tsqr_en = 1; io_mx_no = mx; tick();
  endtask

  task automatic beat(input logic [63:0] d, input bit f);
    io_r_vld = 1; io_r_0 = d; io_tsqr_fi = f; tick();
    io_r_vld = 0; io_tsqr_fi = 0;
  endtask

  task automatic rd(input int r, input int c, input logic [63:0] exp, input string nm);
    io_rd_en = 1; io_rd_row = IDXW'(r); io_rd_col = IDXW'(c); tick();
    io_rd_en = 0;
    chk(nm, io_rd_data, exp);
  endtask

  task automatic nominal();
    arm(2);
    beat(64'h3FF0000000000000, 0);
    beat(64'h4000000000000000, 0);
    beat(64'h4008000000000000, 0);
    io_tsqr_fi = 1; tick(); io_tsqr_fi = 0;
    chk("nom_done", 64'(io_done), 64'd1);
    chk("nom_cnt", 64'(io_beat_cnt), 64'd3);
    chk("nom_mx", 64'(io_mx_lat), 64'd2);
    rd(0, 0, 64'h3FF0000000000000, "nom_rd00");
    rd(0, 1, 64'h4000000000000000, "nom_rd01");
    rd(1, 0, 64'h0, "nom_rd10");
    rd(1, 1, 64'h4008000000000000, "nom_rd11");
  endtask

  initial begin
    tick(); tick();
    reset = 1; cmp_on = 1; tick();
    chk("rst_done", 64'(io_done), 64'd0);
    chk("rst_err", 64'(io_err), 64'd0);
    chk("rst_cnt", 64'(io_beat_cnt), 64'd0);
    chk("rst_rd", io_rd_data, 64'd0);

    nominal();
    io_tsqr_en = 0; tick();
    chk("disarm_done", 64'(io_done), 64'd0);
    chk("disarm_cnt_hold", 64'(io_beat_cnt), 64'd3);

    // underflow
    arm(2);
    beat(64'h1, 0); beat(64'h2, 0);
    io_tsqr_fi = 1; tick(); io_tsqr_fi = 0;
    chk("uf_err", 64'(io_err), 64'd1);
    chk("uf_code", 64'(io_err_code), 64'd1);
    chk("uf_done", 64'(io_done), 64'd0);

    // overflow
    arm(2);
    beat(64'hA, 0); beat(64'hB, 0); beat(64'hC, 0);
    chk("of_pre_err", 64'(io_err), 64'd0);
    beat(64'hD, 0);
    chk("of_code", 64'(io_err_code), 64'd2);
    chk("of_cnt", 64'(io_beat_cnt), 64'd3);
    rd(1, 1, 64'hC, "of_slot2");
    io_tsqr_fi = 1; tick(); io_tsqr_fi = 0;
    chk("of_sticky", 64'(io_err_code), 64'd2);

    // last beat together with finish, then a stray beat
    arm(2);
    beat(64'h11, 0); beat(64'h22, 0); beat(64'h33, 1);
    chk("same_done", 64'(io_done), 64'd1);
    chk("same_err", 64'(io_err), 64'd0);
    beat(64'h44, 0);
    chk("late_err", 64'(io_err_code), 64'd2);
    chk("late_done", 64'(io_done), 64'd0);

    // zero tile count, then a clean rerun
    arm(0);
    chk("zero_code", 64'(io_err_code), 64'd3);
    chk("zero_cnt", 64'(io_beat_cnt), 64'd0);
    rd(1, 1, 64'h0, "zero_cleared");
    nominal();

    // async reset mid-capture, off the clock edge
    arm(2);
    beat(64'h55, 0);
    @(posedge clock); #1 reset = 0;
    #1;
    chk("arst_mx", 64'(io_mx_lat), 64'd0);
    chk("arst_cnt", 64'(io_beat_cnt), 64'd0);
    chk("arst_err", 64'(io_err), 64'd0);
    #2 reset = 1;
    tick();
    beat(64'h66, 0); beat(64'h77, 1);
    chk("noarm_cnt", 64'(io_beat_cnt), 64'd0);
    chk("noarm_done", 64'(io_done), 64'd0);
    nominal();

    // randomized runs
    for (int run = 0; run < 60; run++) begin
      arm(($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 9)));
      for (int cyc = 0; cyc < int'($urandom_range(1, 8)); cyc++) begin
        io_r_vld   = ($urandom_range(0, 2) != 0);
        io_r_0     = {$urandom, $urandom};
        io_tsqr_fi = ($urandom_range(0, 5) == 0);
        io_rd_en   = ($urandom_range(0, 1) == 1);
        io_rd_row  = IDXW'($urandom_range(0, COLS - 1));
        io_rd_col  = IDXW'($urandom_range(0, COLS - 1));
        if ($urandom_range(0, 9) == 0) io_tsqr_en = 0;
        tick();
      end
      io_r_vld = 0; io_tsqr_fi = 0;
      for (int k = 0; k < 4; k++) begin
        io_rd_en  = 1;
        io_rd_row = IDXW'(k >> 1);
        io_rd_col = IDXW'(k & 1);
        tick();
      end
      io_rd_en = 0;
      io_tsqr_en = 0; tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
